led_activity: RTL and testbench



---
 rtl/led_activity_if.sv | 26 ++
 rtl/led_activity.sv | 139 +++++++++++++
 tb/tb_led_activity.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/led_activity_if.sv
// LED status bundle: per-channel mode/link/trigger inputs and LED drive outputs.
interface led_activity_if #(
  parameter int unsigned LEDS = 2
);
  logic                test_mode;
  logic [2*LEDS-1:0]   mode;
  logic [LEDS-1:0]     link;
  logic [LEDS-1:0]     triggers;
  logic [LEDS-1:0]     out;

  modport master (
    output test_mode,
    output mode,
    output link,
    output triggers,
    input  out
  );

  modport slave (
    input  test_mode,
    input  mode,
    input  link,
    input  triggers,
    output out
  );
endinterface

// File: rtl/led_activity.sv
// Multi-channel LED driver: off / steady on / activity blink / link-plus-activity per channel.
// Define LED_DIM_EN to PWM-dim steady-on levels at DIM_DUTY/16.
module led_activity #(
  parameter int unsigned LEDS      = 2,
  parameter int unsigned TICK_BITS = 22,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned DIM_DUTY  = 4
) (
  input  logic          clk,
  input  logic          rst,
  led_activity_if.slave bus
);

  localparam int unsigned MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

  if (ON_TICKS < 1 || OFF_TICKS < 1 || DIM_DUTY > 16) begin : g_bad_params
    $error("led_activity: ON_TICKS/OFF_TICKS must be >= 1 and DIM_DUTY <= 16");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF
  } state_e;

  state_e               state_q [LEDS];
  state_e               state_d [LEDS];
  logic [CNT_W-1:0]     cnt_q   [LEDS];
  logic [CNT_W-1:0]     cnt_d   [LEDS];
  logic [LEDS-1:0]      pend_q, pend_d;
  logic [LEDS-1:0]      out_q, out_d;
  logic [TICK_BITS-1:0] presc_q;

  logic                 tick;
  logic                 pwm;
  logic [LEDS-1:0]      blink_en;
  logic [LEDS-1:0]      base;
  logic [LEDS-1:0]      active;
  logic [LEDS-1:0]      steady;

`ifdef LED_DIM_EN
  logic [3:0] presc_lo;
  assign presc_lo = 4'(presc_q);
  assign pwm      = ({1'b0, presc_lo} < 5'(DIM_DUTY));
`else
  assign pwm = 1'b1;
`endif

  assign tick    = bus.test_mode | (presc_q == '1);
  assign bus.out = out_q;

  always_comb begin
    for (int unsigned i = 0; i < LEDS; i++) begin
      blink_en[i] = bus.mode[2*i+1];
      base[i]     = bus.mode[2*i+1] ? (bus.mode[2*i] & bus.link[i]) : bus.mode[2*i];
      active[i]   = bus.mode[2*i] ? ~bus.link[i] : 1'b1;
      // Only steady-on levels are dimmed; the blink-active level stays fully on.
      steady[i]   = base[i] & pwm;

      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      pend_d[i]  = pend_q[i];

      if (!blink_en[i]) begin
        state_d[i] = S_IDLE;
        cnt_d[i]   = '0;
        pend_d[i]  = 1'b0;
      end else begin
        unique case (state_q[i])
          S_IDLE: begin
            if (bus.triggers[i]) begin
              state_d[i] = S_ON;
              cnt_d[i]   = CNT_W'(ON_TICKS);
            end
          end
          S_ON: begin
            if (bus.triggers[i]) pend_d[i] = 1'b1;
            if (tick) begin
              if (cnt_q[i] == CNT_W'(1)) begin
                state_d[i] = S_OFF;
                cnt_d[i]   = CNT_W'(OFF_TICKS);
              end else begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
              end
            end
          end
          S_OFF: begin
            if (bus.triggers[i]) pend_d[i] = 1'b1;
            if (tick) begin
              if (cnt_q[i] == CNT_W'(1)) begin
                // A trigger on the expiry tick itself must not be lost.
                if (pend_q[i] | bus.triggers[i]) begin
                  state_d[i] = S_ON;
                  cnt_d[i]   = CNT_W'(ON_TICKS);
                  pend_d[i]  = 1'b0;
                end else begin
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
                end
              end else begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
              end
            end
          end
          default: begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
            pend_d[i]  = 1'b0;
          end
        endcase
      end

      out_d[i] = (state_d[i] == S_ON) ? active[i] : steady[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      pend_q  <= '0;
      out_q   <= '0;
      for (int unsigned i = 0; i < LEDS; i++) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      presc_q <= presc_q + TICK_BITS'(1);
      pend_q  <= pend_d;
      out_q   <= out_d;
      for (int unsigned i = 0; i < LEDS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_led_activity.sv
// Directed bench for led_activity: vector table plus reset, prescaler and dimming sequences.
module tb_led_activity;
  localparam int unsigned LEDS = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  led_activity_if #(.LEDS(LEDS)) bus ();

  led_activity #(
    .LEDS      (LEDS),
    .TICK_BITS (4),
    .ON_TICKS  (3),
    .OFF_TICKS (2),
    .DIM_DUTY  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] mode;
    logic [1:0] link;
    logic [1:0] trig;
    logic [1:0] exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
  task automatic step(input logic [3:0] m, input logic [1:0] l, input logic [1:0] t);
    @(negedge clk);
    bus.mode     = m;
    bus.link     = l;
    bus.triggers = t;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [3:0] m, input logic [1:0] l, input logic [1:0] t,
                     input logic [1:0] e);
    vec_t v;
    v.mode = m; v.link = l; v.trig = t; v.exp_out = e;
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n1, n0, n2;
    int hi;

    // ch1 held in mode 01 throughout so out[1]=1 shows it is unaffected.
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    // single blink: 3 on, 2 off, then idle
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    // retrigger in ON and in OFF: exactly two blinks
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b01, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    // trigger exactly on final OFF tick
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    // link-activity: 1, three 0s, then 1; link drop while idle
    add(4'b0111, 2'b01, 2'b00, 2'b11);
    add(4'b0111, 2'b01, 2'b01, 2'b10);
    add(4'b0111, 2'b01, 2'b00, 2'b10);
    add(4'b0111, 2'b01, 2'b00, 2'b10);
    add(4'b0111, 2'b01, 2'b00, 2'b11);
    add(4'b0111, 2'b01, 2'b00, 2'b11);
    add(4'b0111, 2'b01, 2'b00, 2'b11);
    add(4'b0111, 2'b00, 2'b00, 2'b10);
    // 10 <-> 11 mid-blink keeps state, level follows mode
    add(4'b0110, 2'b01, 2'b01, 2'b11);
    add(4'b0111, 2'b01, 2'b00, 2'b10);
    add(4'b0110, 2'b01, 2'b00, 2'b11);
    add(4'b0111, 2'b01, 2'b00, 2'b11);
    add(4'b0111, 2'b01, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    // override 10 -> 01 during ON with pending, then back to 10
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0110, 2'b00, 2'b01, 2'b11);
    add(4'b0101, 2'b00, 2'b00, 2'b11);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    add(4'b0110, 2'b00, 2'b00, 2'b10);
    // ch1 blinks alone, ch0 off
    add(4'b1000, 2'b00, 2'b10, 2'b10);
    add(4'b1000, 2'b00, 2'b00, 2'b10);
    add(4'b1000, 2'b00, 2'b00, 2'b10);
    add(4'b1000, 2'b00, 2'b00, 2'b00);
    add(4'b1000, 2'b00, 2'b00, 2'b00);
    add(4'b1000, 2'b00, 2'b00, 2'b00);

    rst           = 1'b1;
    bus.test_mode = 1'b1;
    bus.mode      = '0;
    bus.link      = '0;
    bus.triggers  = '0;
    #1;
    check("reset_out", 32'(bus.out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].mode, vecs[i].link, vecs[i].trig);
      check($sformatf("vec%0d", i), 32'(bus.out), 32'(vecs[i].exp_out));
    end

    // asynchronous reset mid-blink, off the clock edge
    step(4'b0110, 2'b00, 2'b01);
    step(4'b0110, 2'b00, 2'b00);
    check("pre_rst_blink", 32'(bus.out), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out", 32'(bus.out), 32'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(4'b0110, 2'b00, 2'b00);
      check($sformatf("post_rst%0d", i), 32'(bus.out), 32'd2);
    end

    // prescaled ticks: every 16 cycles with TICK_BITS=4
    bus.test_mode = 1'b0;
    step(4'b0110, 2'b00, 2'b01);
    n1 = 1;
    step(4'b0110, 2'b00, 2'b01);
    while (bus.out[0] === 1'b1 && n1 < 100) begin
      n1++;
      step(4'b0110, 2'b00, 2'b00);
    end
    n0 = 1;
    step(4'b0110, 2'b00, 2'b00);
    while (bus.out[0] === 1'b0 && n0 < 100) begin
      n0++;
      step(4'b0110, 2'b00, 2'b00);
    end
    n2 = 1;
    step(4'b0110, 2'b00, 2'b00);
    while (bus.out[0] === 1'b1 && n2 < 100) begin
      n2++;
      step(4'b0110, 2'b00, 2'b00);
    end
    check("first_on_in_range", 32'(n1 >= 33 && n1 <= 48), 32'd1);
    check("off_len", 32'(n0), 32'd32);
    check("second_on_len", 32'(n2), 32'd48);
    repeat (40) step(4'b0110, 2'b00, 2'b00);
    check("slow_idle", 32'(bus.out), 32'd2);
    bus.test_mode = 1'b1;

`ifdef LED_DIM_EN
    step(4'b0001, 2'b00, 2'b00);
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'b0001, 2'b00, 2'b00);
      if (bus.out[0] === 1'b1) hi++;
    end
    check("dim_high_count", 32'(hi), 32'd4);
`else
    hi = 0;
    for (int i = 0; i < 16; i++) begin
      step(4'b0001, 2'b00, 2'b00);
      if (bus.out[0] === 1'b1) hi++;
    end
    check("steady_high_count", 32'(hi), 32'd16);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
